// File: rtl/group_leaf_switch.sv
// group_leaf_switch: 5-input / 5-output group switch (4 leaf NIs + spine uplink).
// Each input owns a FIFO whose head sits in a register loaded from the memory, so a
// flit spends one cycle in the memory and one in the head stage before it can win
// an output. Heads are routed on their group/leaf header and round-robin arbitrated
// per output; leaf outputs are one-cycle pulses, the uplink output is a holding stage.
module group_leaf_switch #(
  parameter int DATA_W     = 16,
  parameter int GROUP_ID   = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DATA_W-1:0]   loc_in_data,
  input  logic [3:0]            loc_in_valid,
  output logic [3:0]            loc_in_ready,
  output logic [4*DATA_W-1:0]   loc_out_data,
  output logic [3:0]            loc_out_valid,
  input  logic [DATA_W-1:0]     up_in_data,
  input  logic                  up_in_valid,
  output logic                  up_in_ready,
  output logic [DATA_W-1:0]     up_out_data,
  output logic                  up_out_valid,
  input  logic                  up_out_ready,
  output logic [7:0]            drop_count
);

  localparam int NI = 5;                    // inputs 0-3 leaves, 4 uplink
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    GRP      = 4'(GROUP_ID);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] RDY_MAX  = CW'(FIFO_DEPTH - 2);

  logic [DATA_W-1:0] w_in_data [NI];
  logic [DATA_W-1:0] w_head    [NI];
  logic [CW-1:0]     w_cnt     [NI];
  logic [2:0]        w_dst     [NI];
  logic [2:0]        w_gidx    [NI];
  logic [NI-1:0]     w_in_vld, w_full, w_push, w_pop, w_hdrop, w_fwd, w_fdrop, w_gnt;
  logic              w_up_free;
  logic [3:0]        w_drop_sum;
  logic [8:0]        w_drop_tot;
  logic              r_up_vld;
  logic [DATA_W-1:0] r_up_data;
  logic [7:0]        r_drop;

  assign w_up_free    = !r_up_vld || up_out_ready;
  assign up_in_ready  = !w_full[NI-1];
  assign up_out_valid = r_up_vld;
  assign up_out_data  = r_up_data;
  assign drop_count   = r_drop;

  genvar gi;

  // Input FIFOs with registered head stage, plus header decode of the head.
  for (gi = 0; gi < NI; gi++) begin : g_in
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [CW-1:0]     r_mcnt;
    logic              r_hv;
    logic [DATA_W-1:0] r_hd;
    logic              w_load;
    logic [3:0]        w_grp;
    logic [1:0]        w_leaf;

    if (gi < 4) begin : g_leaf
      assign w_in_data[gi]    = loc_in_data[gi*DATA_W +: DATA_W];
      assign w_in_vld[gi]     = loc_in_valid[gi];
      // NI launches regardless of ready; anything hitting a full FIFO is lost
      assign w_fdrop[gi]      = loc_in_valid[gi] && w_full[gi];
      assign loc_in_ready[gi] = (w_cnt[gi] <= RDY_MAX);
    end else begin : g_up
      assign w_in_data[gi] = up_in_data;
      assign w_in_vld[gi]  = up_in_valid;
      assign w_fdrop[gi]   = 1'b0;
    end

    // occupancy counts the head register as well as the memory
    assign w_cnt[gi]  = r_mcnt + CW'(r_hv);
    assign w_full[gi] = (w_cnt[gi] == FULL_CNT);
    assign w_push[gi] = w_in_vld[gi] && !w_full[gi];
    assign w_load     = (r_mcnt != '0) && (!r_hv || w_pop[gi]);
    assign w_head[gi] = r_hd;

    assign w_grp       = r_hd[DATA_W-1 -: 4];
    assign w_leaf      = r_hd[DATA_W-5 -: 2];
    // group 0 is never valid; spine traffic for another group would U-turn
    assign w_hdrop[gi] = r_hv && ((w_grp == 4'd0) || ((gi == NI-1) && (w_grp != GRP)));
    assign w_fwd[gi]   = r_hv && !w_hdrop[gi];
    assign w_dst[gi]   = (w_grp == GRP) ? {1'b0, w_leaf} : 3'd4;

    // FIFO storage write and registered read into the head stage
    always_ff @(posedge clk) begin
      if (w_push[gi]) r_mem[r_wp] <= w_in_data[gi];
      if (w_load)     r_hd <= r_mem[r_rp];
    end

    // FIFO pointers, memory count and head-valid flag
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wp   <= '0;
        r_rp   <= '0;
        r_mcnt <= '0;
        r_hv   <= 1'b0;
      end else begin
        if (w_push[gi]) r_wp <= r_wp + AW'(1);
        if (w_load)     r_rp <= r_rp + AW'(1);
        case ({w_push[gi], w_load})
          2'b10:   r_mcnt <= r_mcnt + CW'(1);
          2'b01:   r_mcnt <= r_mcnt - CW'(1);
          default: r_mcnt <= r_mcnt;
        endcase
        if (w_load)          r_hv <= 1'b1;
        else if (w_pop[gi])  r_hv <= 1'b0;
      end
    end
  end

  // Per-output round-robin arbiters (outputs 0-3 leaves, 4 uplink).
  for (gi = 0; gi < NI; gi++) begin : g_out
    logic [2:0]    r_ptr;
    logic [NI-1:0] w_req;
    logic          w_found;
    logic [2:0]    w_sel;
    logic          w_en;

    // uplink may only be granted when its holding stage can take a flit
    assign w_en = (gi < 4) ? 1'b1 : w_up_free;

    // collect heads that request this output
    always_comb begin
      w_req = '0;
      for (int i = 0; i < NI; i++) w_req[i] = w_fwd[i] && (w_dst[i] == 3'(gi));
    end

    // first requester searching upward from ptr+1
    always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 1; k <= NI; k++) begin
        if (!w_found && w_req[3'((int'(r_ptr) + k) % NI)]) begin
          w_found = 1'b1;
          w_sel   = 3'((int'(r_ptr) + k) % NI);
        end
      end
    end

    assign w_gnt[gi]  = w_found && w_en;
    assign w_gidx[gi] = w_sel;

    // priority pointer follows the last winner
    always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_ptr <= 3'd4;
      else if (w_gnt[gi]) r_ptr <= w_sel;
    end

    if (gi < 4) begin : g_leaf_out
      logic              r_vld;
      logic [DATA_W-1:0] r_data;
      assign loc_out_valid[gi]                 = r_vld;
      assign loc_out_data[gi*DATA_W +: DATA_W] = r_data;

      // leaf output register: one-cycle pulse, data holds between flits
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld  <= 1'b0;
          r_data <= '0;
        end else begin
          r_vld <= w_gnt[gi];
          if (w_gnt[gi]) r_data <= w_head[w_sel];
        end
      end
    end
  end

  // a head leaves its FIFO when dropped or when any output grants it
  always_comb begin
    w_pop = w_hdrop;
    for (int o = 0; o < NI; o++)
      for (int i = 0; i < NI; i++)
        if (w_gnt[o] && (w_gidx[o] == 3'(i))) w_pop[i] = 1'b1;
  end

  // total drops this cycle from full leaf FIFOs and discarded heads
  always_comb begin
    w_drop_sum = '0;
    for (int i = 0; i < NI; i++)
      w_drop_sum = w_drop_sum + 4'(w_fdrop[i]) + 4'(w_hdrop[i]);
    w_drop_tot = 9'(r_drop) + 9'(w_drop_sum);
  end

  // uplink holding stage and saturating drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up_vld  <= 1'b0;
      r_up_data <= '0;
      r_drop    <= '0;
    end else begin
      if (w_gnt[NI-1]) begin
        r_up_vld  <= 1'b1;
        r_up_data <= w_head[w_gidx[NI-1]];
      end else if (up_out_ready) begin
        r_up_vld  <= 1'b0;
      end
      r_drop <= (w_drop_tot > 9'd255) ? 8'hFF : w_drop_tot[7:0];
    end
  end

endmodule

// File: tb/tb_group_leaf_switch.sv
// Directed bench for group_leaf_switch: latency, routing, arbitration order,
// uplink backpressure, drops/saturation and mid-operation reset.
module tb_group_leaf_switch;

  logic        clk;
  logic        reset;
  logic [63:0] loc_in_data;
  logic [3:0]  loc_in_valid;
  logic [3:0]  loc_in_ready;
  logic [63:0] loc_out_data;
  logic [3:0]  loc_out_valid;
  logic [15:0] up_in_data;
  logic        up_in_valid;
  logic        up_in_ready;
  logic [15:0] up_out_data;
  logic        up_out_valid;
  logic        up_out_ready;
  logic [7:0]  drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_loc_seen = 0;
  int up_seen = 0;
  logic [15:0] up_q [$];

  group_leaf_switch #(.DATA_W(16), .GROUP_ID(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .loc_in_data(loc_in_data), .loc_in_valid(loc_in_valid), .loc_in_ready(loc_in_ready),
    .loc_out_data(loc_out_data), .loc_out_valid(loc_out_valid),
    .up_in_data(up_in_data), .up_in_valid(up_in_valid), .up_in_ready(up_in_ready),
    .up_out_data(up_out_data), .up_out_valid(up_out_valid), .up_out_ready(up_out_ready),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output monitor on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (loc_out_valid[i]) n_loc_seen++;
    if (up_out_valid) up_seen++;
    if (up_out_valid && up_out_ready) up_q.push_back(up_out_data);
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base_loc, base_up, qb, idx;
  bit ok_prev, saw_low;

  initial begin
    reset = 1'b1;
    loc_in_data = '0; loc_in_valid = '0;
    up_in_data = '0; up_in_valid = 1'b0; up_out_ready = 1'b1;
    tick(); tick();
    chk("rst_loc_valid", 64'(loc_out_valid), 64'(4'b0000));
    chk("rst_up_valid",  64'(up_out_valid), 64'(1'b0));
    chk("rst_loc_data",  loc_out_data, 64'h0);
    chk("rst_up_data",   64'(up_out_data), 64'h0);
    chk("rst_drop",      64'(drop_count), 64'h0);
    chk("rst_loc_ready", 64'(loc_in_ready), 64'(4'hF));
    chk("rst_up_ready",  64'(up_in_ready), 64'(1'b1));
    reset = 1'b0;
    tick();

    // 1: leaf 0 -> leaf 2, two-edge latency, single pulse
    loc_in_data[15:0] = 16'h58A5; loc_in_valid = 4'b0001;
    tick(); loc_in_valid = '0;
    chk("t1_n_valid", 64'(loc_out_valid), 64'(4'b0000));
    tick();
    chk("t1_n1_valid", 64'(loc_out_valid), 64'(4'b0000));
    tick();
    chk("t1_n2_valid", 64'(loc_out_valid), 64'(4'b0100));
    chk("t1_n2_data", 64'(loc_out_data[47:32]), 64'h58A5);
    tick();
    chk("t1_pulse_end", 64'(loc_out_valid), 64'(4'b0000));
    chk("t1_data_hold", 64'(loc_out_data[47:32]), 64'h58A5);

    // 2: leaf 1 -> uplink, held stable under backpressure
    up_out_ready = 1'b0; qb = up_q.size();
    loc_in_data[31:16] = 16'h2003; loc_in_valid = 4'b0010;
    tick(); loc_in_valid = '0;
    tick();
    chk("t2_n1_upvalid", 64'(up_out_valid), 64'(1'b0));
    tick();
    chk("t2_upvalid", 64'(up_out_valid), 64'(1'b1));
    chk("t2_updata", 64'(up_out_data), 64'h2003);
    repeat (3) tick();
    chk("t2_hold_valid", 64'(up_out_valid), 64'(1'b1));
    chk("t2_hold_data", 64'(up_out_data), 64'h2003);
    up_out_ready = 1'b1;
    tick();
    chk("t2_drop_valid", 64'(up_out_valid), 64'(1'b0));
    chk("t2_xfers", 64'(up_q.size() - qb), 64'd1);

    // 3: three leaves to leaf 3 in one cycle -> round-robin order 0,1,3
    loc_in_data[15:0] = 16'h5C01; loc_in_data[31:16] = 16'h5C02; loc_in_data[63:48] = 16'h5C03;
    loc_in_valid = 4'b1011;
    tick(); loc_in_valid = '0;
    tick();
    tick();
    chk("t3_v0", 64'(loc_out_valid), 64'(4'b1000));
    chk("t3_d0", 64'(loc_out_data[63:48]), 64'h5C01);
    tick();
    chk("t3_v1", 64'(loc_out_valid), 64'(4'b1000));
    chk("t3_d1", 64'(loc_out_data[63:48]), 64'h5C02);
    tick();
    chk("t3_v2", 64'(loc_out_valid), 64'(4'b1000));
    chk("t3_d2", 64'(loc_out_data[63:48]), 64'h5C03);
    tick();
    chk("t3_end", 64'(loc_out_valid), 64'(4'b0000));

    // 4: leaf 2 streams to a stalled uplink following the NI ready rule
    qb = up_q.size(); idx = 0; saw_low = 1'b0;
    ok_prev = loc_in_ready[2];
    for (int c = 0; c < 40; c++) begin
      if (ok_prev && idx < 6) begin
        loc_in_data[47:32] = 16'h2001 + 16'(idx);
        loc_in_valid = 4'b0100;
        idx++;
      end else begin
        loc_in_valid = '0;
      end
      if (!loc_in_ready[2]) saw_low = 1'b1;
      ok_prev = loc_in_ready[2];
      up_out_ready = (c >= 10);
      tick();
    end
    loc_in_valid = '0;
    chk("t4_launched", 64'(idx), 64'd6);
    chk("t4_ready_low", 64'(saw_low), 64'd1);
    chk("t4_no_drop", 64'(drop_count), 64'd0);
    chk("t4_count", 64'(up_q.size() - qb), 64'd6);
    for (int k = 0; k < 6; k++)
      if (qb + k < up_q.size())
        chk($sformatf("t4_order%0d", k), 64'(up_q[qb + k]), 64'h2001 + 64'(k));

    // 5: spine flits that must be dropped, then one delivered to leaf 1
    base_loc = n_loc_seen; base_up = up_seen;
    chk("t5_up_ready", 64'(up_in_ready), 64'(1'b1));
    up_in_data = 16'h2003; up_in_valid = 1'b1;
    tick(); up_in_data = 16'h0011;
    tick(); up_in_valid = 1'b0;
    repeat (4) tick();
    chk("t5_drop2", 64'(drop_count), 64'd2);
    chk("t5_no_loc", 64'(n_loc_seen - base_loc), 64'd0);
    chk("t5_no_up", 64'(up_seen - base_up), 64'd0);
    up_in_data = 16'h5401; up_in_valid = 1'b1;
    tick(); up_in_valid = 1'b0;
    tick(); tick();
    chk("t5_valid", 64'(loc_out_valid), 64'(4'b0010));
    chk("t5_data", 64'(loc_out_data[31:16]), 64'h5401);

    // drop counter saturation with five sources dropping every cycle
    tick(); base_loc = n_loc_seen;
    loc_in_data = {4{16'h03FF}}; loc_in_valid = 4'hF;
    up_in_data = 16'h0ABC; up_in_valid = 1'b1;
    repeat (60) tick();
    loc_in_valid = '0; up_in_valid = 1'b0;
    repeat (5) tick();
    chk("sat_drop", 64'(drop_count), 64'd255);
    chk("sat_no_loc", 64'(n_loc_seen - base_loc), 64'd0);

    // 6: reset mid-operation with flits buffered behind a stalled uplink
    up_out_ready = 1'b0;
    loc_in_data = {16'h2014, 16'h2013, 16'h2012, 16'h2011}; loc_in_valid = 4'hF;
    tick(); loc_in_valid = '0;
    repeat (4) tick();
    chk("t6_pre_upvalid", 64'(up_out_valid), 64'(1'b1));
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_loc_valid", 64'(loc_out_valid), 64'(4'b0000));
    chk("t6_rst_up_valid", 64'(up_out_valid), 64'(1'b0));
    chk("t6_rst_loc_ready", 64'(loc_in_ready), 64'(4'hF));
    chk("t6_rst_up_ready", 64'(up_in_ready), 64'(1'b1));
    chk("t6_rst_drop", 64'(drop_count), 64'd0);
    tick(); tick();
    reset = 1'b0;
    base_loc = n_loc_seen; base_up = up_seen;
    up_out_ready = 1'b1;
    repeat (10) tick();
    chk("t6_no_stale_loc", 64'(n_loc_seen - base_loc), 64'd0);
    chk("t6_no_stale_up", 64'(up_seen - base_up), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
